mux_arb_n_1: RTL and testbench

//  Parametrised N-to-1 selector with a registered output and valid/ready handshakes.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux_arb_n_1_rr_pick.sv | 38 +++
 rtl/mux_arb_n_1.sv | 116 +++++++++++
 tb/tb_mux_arb_n_1.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared mode/state encodings and helpers for mux_arb_n_1
package mux_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // Round-robin pointer advance: the channel after the winner, wrapping at n.
    function automatic int next_index(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mux_arb_n_1_rr_pick.sv
// rtl/mux_arb_n_1_rr_pick.sv - combinational rotate/priority/rotate-back round-robin picker
module rr_pick #(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gidx,
    output logic          any
);

    localparam logic [SW:0] N_W = (SW + 1)'(N);

    logic [N-1:0]  rot;
    logic [SW-1:0] off;
    logic [SW:0]   sum;

    always_comb begin
        rot  = N'({req, req} >> ptr);
        off  = '0;
        any  = 1'b0;
        // Descending scan so the lowest set bit (closest to ptr) wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SW'(k);
                any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        gidx = sum[SW-1:0];
        gnt  = any ? (N'(1) << gidx) : '0;
    end

endmodule

// File: rtl/mux_arb_n_1.sv
// rtl/mux_arb_n_1.sv - N:1 registered selector, fixed or round-robin; MUX_ARB_STATS_EN adds xfer_cnt
module mux_arb_n_1
    import mux_arb_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 5,
    localparam int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_valid,
    input  logic             out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      xfer_cnt
`endif
);

    localparam logic [SW:0] N_W = (SW + 1)'(N);

    state_e        state, state_d;
    logic          ld;
    logic [SW-1:0] ptr;
    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_idx;
    logic          rr_any;
    logic          sel_ok;
    logic [N-1:0]  grant;
    logic [SW-1:0] gidx;
    logic          any;

    rr_pick #(.N(N)) u_rr_pick (
        .req  (in_valid),
        .ptr  (ptr),
        .gnt  (rr_gnt),
        .gidx (rr_idx),
        .any  (rr_any)
    );

    assign out_valid = (state == ST_FULL);
    assign ld        = (state == ST_EMPTY) | out_ready;
    assign sel_ok    = ({1'b0, sel} < N_W);

    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        if (ld) begin
            if (mode == MODE_RR) begin
                grant = rr_gnt;
                gidx  = rr_idx;
                any   = rr_any;
            end else if (sel_ok && in_valid[sel]) begin
                grant = N'(1) << sel;
                gidx  = sel;
                any   = 1'b1;
            end
        end
    end

    // Suppressed during reset so no upstream word is consumed and then lost.
    assign in_ready = rst ? '0 : grant;

    always_comb begin
        state_d = state;
        if (any) begin
            state_d = ST_FULL;
        end else if (out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (any) begin
            out_data <= in_data[gidx*WIDTH +: WIDTH];
            out_src  <= gidx;
            if (mode == MODE_RR) begin
                ptr <= SW'(next_index(int'(gidx), N));
            end
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (out_valid && out_ready && (cnt != 16'hFFFF)) begin
            cnt <= cnt + 16'd1;
        end
    end

    assign xfer_cnt = cnt;
`endif

endmodule

// File: tb/tb_mux_arb_n_1.sv
// tb/tb_mux_arb_n_1.sv - directed vector table plus randomized reference-model run for mux_arb_n_1
module tb_mux_arb_n_1;

    localparam int N  = 4;
    localparam int W  = 5;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_src;
    logic           out_valid;
    logic           out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]    xfer_cnt;
`endif

    always #5 clk = ~clk;

    mux_arb_n_1 #(.N(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: output register contents, rotation pointer, transfer count.
    bit m_ov;
    int m_od, m_src, m_ptr, m_cnt;

    typedef struct {
        bit        r;
        bit        m;
        int        s;
        bit [3:0]  v;
        bit [19:0] d;
        bit        ordy;
        bit [3:0]  e_rdy;
        bit        e_ov;
        int        e_od;
        int        e_src;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [19:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {c3[4:0], c2[4:0], c1[4:0], c0[4:0]};
    endfunction

    function automatic vec_t mk(input bit r, input bit m, input int s, input bit [3:0] v,
                                input bit [19:0] d, input bit ordy, input bit [3:0] e_rdy,
                                input bit e_ov, input int e_od, input int e_src);
        vec_t x;
        x.r = r; x.m = m; x.s = s; x.v = v; x.d = d; x.ordy = ordy;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_od = e_od; x.e_src = e_src;
        return x;
    endfunction

    // Which channel the rules grant this cycle, or -1.
    function automatic int model_grant(input bit r, input bit m, input int s, input bit [3:0] v,
                                       input bit ordy);
        if (r) return -1;
        if (m_ov && !ordy) return -1;
        if (!m) return (s < N && v[s]) ? s : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input bit r, input bit m, input int s, input bit [3:0] v,
                        input bit [19:0] d, input bit ordy, output bit [3:0] rdy_seen);
        int g;
        bit [3:0] e_rdy;
        rst = r; mode = m; sel = s[SW-1:0]; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        g = model_grant(r, m, s, v, ordy);
        e_rdy = (g < 0) ? 4'b0000 : 4'(1 << g);
        rdy_seen = in_ready;
        chk("in_ready", int'(in_ready), int'(e_rdy));
        @(posedge clk);
        if (r) begin
            m_cnt = 0;
        end else if (m_ov && ordy && m_cnt < 65535) begin
            m_cnt++;
        end
        if (r) begin
            m_ov = 0; m_od = 0; m_src = 0; m_ptr = 0;
        end else if (g >= 0) begin
            m_ov = 1; m_od = int'(d[g*W +: W]); m_src = g;
            if (m) m_ptr = (g + 1) % N;
        end else if (ordy) begin
            m_ov = 0;
        end
        #1;
        chk("out_valid", int'(out_valid), int'(m_ov));
        if (m_ov || r) begin
            chk("out_data", int'(out_data), m_od);
            chk("out_src", int'(out_src), m_src);
        end
`ifdef MUX_ARB_STATS_EN
        chk("xfer_cnt", int'(xfer_cnt), m_cnt);
`endif
    endtask

    initial begin
        bit [19:0] rr_d;
        bit [3:0]  rdy;
        rr_d = pk('h10, 'h11, 'h12, 'h13);
        m_ov = 0; m_od = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
        rst = 1; mode = 0; sel = '0; in_valid = '0; in_data = '0; out_ready = 0;

        tbl[0]  = mk(1, 0, 0, 4'b1111, rr_d,                 1, 4'b0000, 0, 'h00, 0);
        tbl[1]  = mk(0, 0, 2, 4'b1111, pk(0, 0, 'h1A, 0),    1, 4'b0100, 1, 'h1A, 2);
        tbl[2]  = mk(1, 1, 0, 4'b1111, rr_d,                 1, 4'b0000, 0, 'h00, 0);
        tbl[3]  = mk(0, 1, 0, 4'b1111, rr_d,                 1, 4'b0001, 1, 'h10, 0);
        tbl[4]  = mk(0, 1, 0, 4'b1111, rr_d,                 1, 4'b0010, 1, 'h11, 1);
        tbl[5]  = mk(0, 1, 0, 4'b1111, rr_d,                 1, 4'b0100, 1, 'h12, 2);
        tbl[6]  = mk(0, 1, 0, 4'b1111, rr_d,                 1, 4'b1000, 1, 'h13, 3);
        tbl[7]  = mk(0, 1, 0, 4'b1111, rr_d,                 1, 4'b0001, 1, 'h10, 0);
        tbl[8]  = mk(0, 0, 0, 4'b0001, pk('h07, 0, 0, 0),    1, 4'b0001, 1, 'h07, 0);
        for (int i = 9; i <= 13; i++) begin
            tbl[i] = mk(0, 1, 1, 4'b1111, rr_d,              0, 4'b0000, 1, 'h07, 0);
        end
        tbl[14] = mk(0, 1, 0, 4'b0010, pk(0, 'h15, 0, 0),    1, 4'b0010, 1, 'h15, 1);
        tbl[15] = mk(0, 1, 0, 4'b0100, pk(0, 0, 'h02, 0),    1, 4'b0100, 1, 'h02, 2);
        tbl[16] = mk(0, 1, 0, 4'b0010, pk(0, 'h01, 0, 0),    1, 4'b0010, 1, 'h01, 1);
        tbl[17] = mk(0, 1, 0, 4'b1001, pk('h1C, 0, 0, 'h03), 1, 4'b1000, 1, 'h03, 3);
        tbl[18] = mk(0, 0, 3, 4'b0001, pk('h09, 0, 0, 0),    1, 4'b0000, 0, 'h00, 0);
        tbl[19] = mk(0, 1, 0, 4'b0010, pk(0, 'h0B, 0, 0),    0, 4'b0010, 1, 'h0B, 1);
        tbl[20] = mk(1, 1, 0, 4'b1111, rr_d,                 0, 4'b0000, 0, 'h00, 0);
        tbl[21] = mk(0, 1, 0, 4'b1111, rr_d,                 1, 4'b0001, 1, 'h10, 0);

        @(negedge clk);
        for (int i = 0; i < 22; i++) begin
            step(tbl[i].r, tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].d, tbl[i].ordy, rdy);
            chk($sformatf("tbl%0d_in_ready", i), int'(rdy), int'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
            if (tbl[i].e_ov || tbl[i].r) begin
                chk($sformatf("tbl%0d_out_data", i), int'(out_data), tbl[i].e_od);
                chk($sformatf("tbl%0d_out_src", i), int'(out_src), tbl[i].e_src);
            end
        end

        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(63) == 0, 1'($urandom), int'($urandom_range(N - 1)),
                 4'($urandom), 20'($urandom), $urandom_range(3) != 0, rdy);
            chk("onehot", int'($countones(rdy) <= 1), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
